// File: rtl/ram_ctrl_pkg.sv
// Shared types and widths for the ram_ctrl SRAM access controller.
package ram_ctrl_pkg;

    localparam int CNT_W  = 4;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/ram_ctrl.sv
// CPU-to-SRAM access controller: one access per WAIT_CYCLES+4 cycles,
// with an active-low write strobe lasting WAIT_CYCLES cycles.
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ,
    input  logic              WE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] WDATA,
    output logic [DATA_W-1:0] RDATA,
    output logic              ACK,
    output logic              BUSY,
    output logic              RAM_CS,
    output logic              RAM_WR,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [DATA_W-1:0] RAM_DIN,
    input  logic [DATA_W-1:0] RAM_DOUT
);

    localparam logic [CNT_W-1:0] LP_WAIT = CNT_W'(WAIT_CYCLES);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic [DATA_W-1:0] r_rdata;
    logic              r_ack;
    logic              r_busy;
    logic              r_ram_cs;
    logic              r_ram_wr;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_din;

    // FSM, wait counter, request latches and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_rdata    <= '0;
            r_ack      <= 1'b0;
            r_busy     <= 1'b0;
            r_ram_cs   <= 1'b1;
            r_ram_wr   <= 1'b1;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack    <= 1'b0;
                    r_ram_wr <= 1'b1;
                    if (REQ) begin
                        r_we       <= WE;
                        r_ram_addr <= ADDR;
                        r_ram_din  <= WDATA;
                        r_ram_cs   <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SETUP;
                    end else begin
                        r_ram_cs <= 1'b1;
                        r_busy   <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    r_ram_wr <= ~r_we;
                    r_cnt    <= LP_WAIT;
                    r_state  <= ST_STROBE;
                end
                ST_STROBE: begin
                    // a count of 0 or 1 both end the strobe, so an illegal 0 cannot hang
                    if (r_cnt <= 4'd1) begin
                        r_cnt    <= 4'd0;
                        r_ram_wr <= 1'b1;
                        r_state  <= ST_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (!r_we) begin
                        r_rdata <= RAM_DOUT;
                    end
                    r_ram_cs <= 1'b1;
                    r_ack    <= 1'b1;
                    r_state  <= ST_DONE;
                end
                ST_DONE: begin
                    r_ack   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ack    <= 1'b0;
                    r_busy   <= 1'b0;
                    r_ram_cs <= 1'b1;
                    r_ram_wr <= 1'b1;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign RDATA    = r_rdata;
    assign ACK      = r_ack;
    assign BUSY     = r_busy;
    assign RAM_CS   = r_ram_cs;
    assign RAM_WR   = r_ram_wr;
    assign RAM_ADDR = r_ram_addr;
    assign RAM_DIN  = r_ram_din;

endmodule
